// File: rtl/fp_mul_result_buffer.sv
// ============================================================================
// Module   : fp_mul_result_buffer
// Desc     : DEPTH-entry FIFO holding FP multiplier products with their
//            {n,o,u} flags, sticky flag accumulation and, when the macro
//            FPMUL_STATS_EN is defined, saturating per-flag event counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_mul_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic                       in_u,
    input  logic                       in_o,
    input  logic                       in_n,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [2:0]                 sticky_flags,
    input  logic                       clear_sticky
`ifdef FPMUL_STATS_EN
    ,
    output logic [CNT_W-1:0]           stat_u_cnt,
    output logic [CNT_W-1:0]           stat_o_cnt,
    output logic [CNT_W-1:0]           stat_n_cnt
`endif
);

    localparam int                   c_PTR_W    = $clog2(DEPTH);
    localparam int                   c_LVL_W    = c_PTR_W + 1;
    localparam int                   c_ENTRY_W  = 35;
    localparam logic [c_LVL_W-1:0]   c_DEPTH    = c_LVL_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [2:0]           r_sticky;

    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_in_flags;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_in_flags = {in_n, in_o, in_u};

    // Handshake flags come only from registered occupancy, never from out_ready.
    assign in_ready  = (r_level < c_DEPTH);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_head     = r_mem[r_rptr];
    assign out_result = out_valid ? w_head[31:0]  : 32'd0;
    assign out_flags  = out_valid ? w_head[34:32] : 3'd0;
    assign level        = r_level;
    assign sticky_flags = r_sticky;

    // Storage is deliberately unreset; the empty-masking above hides stale data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_in_flags, in_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
        end else if (w_push) begin
            r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A flag set by this cycle's push survives a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (clear_sticky ? 3'd0 : r_sticky) | (w_push ? w_in_flags : 3'd0);
        end
    end

`ifdef FPMUL_STATS_EN
    logic [2:0][CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clear_sticky) begin
                    r_cnt[i] <= (w_push && w_in_flags[i]) ? CNT_W'(1) : '0;
                end else if (w_push && w_in_flags[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stat_u_cnt = r_cnt[0];
    assign stat_o_cnt = r_cnt[1];
    assign stat_n_cnt = r_cnt[2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_result_buffer.sv
// ============================================================================
// Module   : tb_fp_mul_result_buffer
// Desc     : Self-checking bench for fp_mul_result_buffer (table vectors,
//            queue-model random traffic, reset and counter corner cases).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_result = 32'd0;
    logic              in_u = 1'b0;
    logic              in_o = 1'b0;
    logic              in_n = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [2:0]        out_flags;
    logic [LVL_W-1:0]  level;
    logic [2:0]        sticky_flags;
    logic              clear_sticky = 1'b0;
`ifdef FPMUL_STATS_EN
    logic [CNT_W-1:0]  stat_u_cnt;
    logic [CNT_W-1:0]  stat_o_cnt;
    logic [CNT_W-1:0]  stat_n_cnt;
`endif

    fp_mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_u         (in_u),
        .in_o         (in_o),
        .in_n         (in_n),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .level        (level),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky)
`ifdef FPMUL_STATS_EN
        ,
        .stat_u_cnt   (stat_u_cnt),
        .stat_o_cnt   (stat_o_cnt),
        .stat_n_cnt   (stat_n_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: an ordered queue of {flags,result} plus sticky/counters.
    logic [34:0] mq[$];
    logic [2:0]  m_st = 3'd0;
    int          m_cnt[3] = '{0, 0, 0};

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [2:0]  fl;
        logic        ordy;
        logic        clr;
        int          e_lvl;
        logic        e_ov;
        logic [31:0] e_res;
        logic [2:0]  e_fl;
        logic        e_ir;
        logic [2:0]  e_st;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic iv, logic [31:0] res, logic [2:0] fl, logic ordy,
                                logic clr, int lvl, logic ov, logic [31:0] eres,
                                logic [2:0] efl, logic ir, logic [2:0] st);
        vec_t v;
        v.iv = iv; v.res = res; v.fl = fl; v.ordy = ordy; v.clr = clr;
        v.e_lvl = lvl; v.e_ov = ov; v.e_res = eres; v.e_fl = efl; v.e_ir = ir; v.e_st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] res, input logic [2:0] fl,
                         input logic ordy, input logic clr);
        in_valid     = iv;
        in_result    = res;
        {in_n, in_o, in_u} = fl;
        out_ready    = ordy;
        clear_sticky = clr;
    endtask

    task automatic model_step();
        bit         rdy;
        bit         ov;
        bit         psh;
        bit         pp;
        logic [2:0] f;
        rdy = (mq.size() < DEPTH);
        ov  = (mq.size() != 0);
        psh = in_valid && rdy;
        pp  = ov && out_ready;
        f   = {in_n, in_o, in_u};
        if (pp)  void'(mq.pop_front());
        if (psh) mq.push_back({f, in_result});
        m_st = (clear_sticky ? 3'd0 : m_st) | (psh ? f : 3'd0);
        for (int i = 0; i < 3; i++) begin
            if (clear_sticky)                          m_cnt[i] = (psh && f[i]) ? 1 : 0;
            else if (psh && f[i] && m_cnt[i] < CMAX)   m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_st = 3'd0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        logic [34:0] h;
        h = (mq.size() != 0) ? mq[0] : 35'd0;
        chk({tag, ".level"},     level,        mq.size());
        chk({tag, ".in_ready"},  in_ready,     mq.size() < DEPTH);
        chk({tag, ".out_valid"}, out_valid,    mq.size() != 0);
        chk({tag, ".out_result"}, out_result,  h[31:0]);
        chk({tag, ".out_flags"}, out_flags,    h[34:32]);
        chk({tag, ".sticky"},    sticky_flags, m_st);
`ifdef FPMUL_STATS_EN
        chk({tag, ".stat_u"},    stat_u_cnt,   m_cnt[0]);
        chk({tag, ".stat_o"},    stat_o_cnt,   m_cnt[1]);
        chk({tag, ".stat_n"},    stat_n_cnt,   m_cnt[2]);
`endif
    endtask

    initial begin
        //          iv  result        fl    ordy clr | lvl ov  result       fl    ir   st
        tbl[0]  = mk(1, 32'h40400000, 3'b000, 0, 0,  1, 1, 32'h40400000, 3'b000, 1, 3'b000);
        tbl[1]  = mk(1, 32'h3F800000, 3'b001, 0, 0,  2, 1, 32'h40400000, 3'b000, 1, 3'b001);
        tbl[2]  = mk(1, 32'h40000000, 3'b000, 0, 0,  3, 1, 32'h40400000, 3'b000, 1, 3'b001);
        tbl[3]  = mk(1, 32'hC0A00000, 3'b100, 0, 0,  4, 1, 32'h40400000, 3'b000, 0, 3'b101);
        tbl[4]  = mk(1, 32'h41200000, 3'b010, 0, 0,  4, 1, 32'h40400000, 3'b000, 0, 3'b101);
        tbl[5]  = mk(1, 32'h41200000, 3'b010, 1, 0,  3, 1, 32'h3F800000, 3'b001, 1, 3'b101);
        tbl[6]  = mk(1, 32'h41200000, 3'b010, 0, 0,  4, 1, 32'h3F800000, 3'b001, 0, 3'b111);
        tbl[7]  = mk(0, 32'h00000000, 3'b000, 1, 0,  3, 1, 32'h40000000, 3'b000, 1, 3'b111);
        tbl[8]  = mk(0, 32'h00000000, 3'b000, 1, 0,  2, 1, 32'hC0A00000, 3'b100, 1, 3'b111);
        tbl[9]  = mk(0, 32'h00000000, 3'b000, 1, 0,  1, 1, 32'h41200000, 3'b010, 1, 3'b111);
        tbl[10] = mk(0, 32'h00000000, 3'b000, 1, 0,  0, 0, 32'h00000000, 3'b000, 1, 3'b111);
        tbl[11] = mk(0, 32'h00000000, 3'b000, 1, 0,  0, 0, 32'h00000000, 3'b000, 1, 3'b111);
        tbl[12] = mk(1, 32'h7F800000, 3'b010, 0, 1,  1, 1, 32'h7F800000, 3'b010, 1, 3'b010);
        tbl[13] = mk(0, 32'h00000000, 3'b000, 0, 1,  1, 1, 32'h7F800000, 3'b010, 1, 3'b000);
        tbl[14] = mk(0, 32'h00000000, 3'b000, 1, 0,  0, 0, 32'h00000000, 3'b000, 1, 3'b000);

        // Reset state, observed before any clock edge.
        #1;
        chk("rst.level",     level,        0);
        chk("rst.in_ready",  in_ready,     1);
        chk("rst.out_valid", out_valid,    0);
        chk("rst.out_result", out_result,  0);
        chk("rst.out_flags", out_flags,    0);
        chk("rst.sticky",    sticky_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; row 0 lands on the first edge after reset release.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].res, tbl[i].fl, tbl[i].ordy, tbl[i].clr);
            tick();
            chk($sformatf("row%0d.level", i),     level,        tbl[i].e_lvl);
            chk($sformatf("row%0d.out_valid", i), out_valid,    tbl[i].e_ov);
            chk($sformatf("row%0d.out_result", i), out_result,  tbl[i].e_res);
            chk($sformatf("row%0d.out_flags", i), out_flags,    tbl[i].e_fl);
            chk($sformatf("row%0d.in_ready", i),  in_ready,     tbl[i].e_ir);
            chk($sformatf("row%0d.sticky", i),    sticky_flags, tbl[i].e_st);
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            tick();
            cmp_model($sformatf("rnd%0d", i));
        end

        drive(0, 0, 0, 1, 0);
        for (int i = 0; i <= DEPTH; i++) tick();
        cmp_model("drain");

`ifdef FPMUL_STATS_EN
        // Counter saturation: five underflow pushes into a 2-bit counter.
        drive(0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h00000001 + i, 3'b001, 1, 0);
            tick();
        end
        chk("sat.stat_u", stat_u_cnt, 3);
        chk("sat.stat_o", stat_o_cnt, 0);
        chk("sat.stat_n", stat_n_cnt, 0);
        cmp_model("sat");
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i <= DEPTH; i++) tick();
`endif

        // Streaming push/pop through pointer wrap, then async reset mid-stream.
        drive(0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h3F000000 + i, 3'b010, 1, 0);
            tick();
            cmp_model($sformatf("strm%0d", i));
            if (i == 6) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.level",     level,        0);
        chk("arst.out_valid", out_valid,    0);
        chk("arst.sticky",    sticky_flags, 0);
        chk("arst.in_ready",  in_ready,     1);
        chk("arst.out_result", out_result,  0);
        chk("arst.out_flags", out_flags,    0);
`ifdef FPMUL_STATS_EN
        chk("arst.stat_o",    stat_o_cnt,   0);
`endif
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h40400000, 3'b000, 0, 0);
        tick();
        cmp_model("post_rst");
        chk("post_rst.head", out_result, 32'h40400000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
